// File: rtl/ame_norm_arbiter.sv
// Round-robin arbiter sharing one ame_num_normal engine among NUM_REQ requesters.
// Latency: request handshake in cycle t -> rsp_valid_o from t+2; one op per 2 cycles peak.
// Backpressure: a held response (rsp_valid_o && !rsp_ready_i) blocks all grants.

// Normalizer engine: sign(x)*(|x|>>s), result and done registered one cycle after init.
module ame_num_normal #(
  parameter int COMP_DATA_BITS = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              comp_init_i,
  input  logic [COMP_DATA_BITS-1:0]         comp_data_i,
  input  logic [$clog2(COMP_DATA_BITS)-1:0] comp_shift_i,
  output logic                              comp_done_o,
  output logic [COMP_DATA_BITS-1:0]         comp_data_o
);

  logic                      neg;
  logic [COMP_DATA_BITS-1:0] mag;
  logic [COMP_DATA_BITS-1:0] shifted;
  logic [COMP_DATA_BITS-1:0] result;
  logic                      done_q;
  logic [COMP_DATA_BITS-1:0] res_q;

  // Shift the magnitude so truncation goes toward zero, then restore the sign.
  always_comb begin
    neg     = comp_data_i[COMP_DATA_BITS-1];
    mag     = neg ? (~comp_data_i + 1'b1) : comp_data_i;
    shifted = mag >> comp_shift_i;
    result  = neg ? (~shifted + 1'b1) : shifted;
  end

  // Register the result on init and pulse done in the following cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= comp_init_i;
      if (comp_init_i) res_q <= result;
    end
  end

  assign comp_done_o = done_q;
  assign comp_data_o = res_q;

endmodule

// Round-robin front end around the shared normalizer with a one-entry response register.
// Latency: grant in cycle t, engine done at t+1, rsp_valid_o visible from t+2.
// Backpressure: no grant while in flight or while the response is held by the consumer.
module ame_norm_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ*DATA_BITS-1:0]           req_data_i,
  input  logic [NUM_REQ*$clog2(DATA_BITS)-1:0]   req_shift_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [DATA_BITS-1:0]                   rsp_data_o,
  output logic [ID_BITS-1:0]                     rsp_id_o,
  output logic                                   busy_o
);

  localparam int SHIFT_BITS = $clog2(DATA_BITS);

  logic [ID_BITS-1:0]    ptr;
  logic [ID_BITS-1:0]    grant;
  logic [ID_BITS-1:0]    id_q;
  logic                  any_req;
  logic                  issue;
  logic                  in_flight;
  logic                  eng_init;
  logic                  eng_done;
  logic [DATA_BITS-1:0]  eng_in;
  logic [SHIFT_BITS-1:0] eng_shift;
  logic [DATA_BITS-1:0]  eng_out;
  int                    idx;

  // Find the first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid_i[idx]) begin
        any_req = 1'b1;
        grant   = ID_BITS'(idx);
      end
    end
  end

  // Issue only when the engine is idle and the response slot is empty or draining now.
  assign issue = any_req && !in_flight && (!rsp_valid_o || rsp_ready_i);

  // Grant and engine operands exist only in the issue cycle; zeros otherwise.
  always_comb begin
    req_ready_o = '0;
    eng_init    = issue;
    eng_in      = '0;
    eng_shift   = '0;
    if (issue) begin
      req_ready_o[grant] = 1'b1;
      eng_in             = req_data_i[int'(grant)*DATA_BITS +: DATA_BITS];
      eng_shift          = req_shift_i[int'(grant)*SHIFT_BITS +: SHIFT_BITS];
    end
  end

  ame_num_normal #(
    .COMP_DATA_BITS(DATA_BITS)
  ) u_norm (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .comp_init_i (eng_init),
    .comp_data_i (eng_in),
    .comp_shift_i(eng_shift),
    .comp_done_o (eng_done),
    .comp_data_o (eng_out)
  );

  // Track the in-flight operation and advance the round-robin pointer past each winner.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr       <= '0;
      id_q      <= '0;
      in_flight <= 1'b0;
    end else begin
      if (issue) begin
        ptr       <= (grant == ID_BITS'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        id_q      <= grant;
        in_flight <= 1'b1;
      end else if (eng_done) begin
        in_flight <= 1'b0;
      end
    end
  end

  // Response register: load on engine done, clear on consumer handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
    end else begin
      if (eng_done) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= eng_out;
        rsp_id_o    <= id_q;
      end else if (rsp_valid_o && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = in_flight | rsp_valid_o;

endmodule

// File: tb/tb_ame_norm_arbiter.sv
// Scoreboard bench for ame_norm_arbiter: grants predicted by a round-robin model,
// results by signed division, responses popped and compared by a negedge monitor.
module tb_ame_norm_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 6;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_shift;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
  logic            busy;

  ame_norm_arbiter #(.NUM_REQ(N), .DATA_BITS(DW)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_data_i (req_data),
    .req_shift_i(req_shift),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_id_o   (rsp_id),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dat;
    logic [1:0]    id;
    int            gcyc;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            mptr = 0;
  bit            head_seen = 0;
  bit            mon_en = 0;
  bit            vld[N];
  logic [DW-1:0] dat[N];
  logic [SW-1:0] sh[N];
  bit            accepted[N];

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_shift = '0;
    for (int k = 0; k < N; k++) begin
      req_valid[k]           = vld[k];
      req_data[k*DW +: DW]   = dat[k];
      req_shift[k*SW +: SW]  = sh[k];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference arithmetic: signed division by 2^s truncates toward zero.
  function automatic logic [DW-1:0] golden(input logic [DW-1:0] x, input int s);
    longint sx;
    longint d;
    sx = longint'(x);
    d  = longint'(1) << s;
    return 64'(sx / d);
  endfunction

  // Monitor: predict grants, check busy, and compare responses against the queue head.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      bit   exp_issue;
      int   w;
      exp_t e;
      chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
      exp_issue = (req_valid != 0) && (q.size() == 0 || (rsp_valid && rsp_ready));
      chk("issue", {63'd0, req_ready != 0}, {63'd0, exp_issue});
      if (req_ready != 0) begin
        w = -1;
        for (int i = 0; i < N; i++) begin
          if (w < 0 && req_valid[(mptr + i) % N]) w = (mptr + i) % N;
        end
        if (w < 0) w = 0;
        chk("grant", {60'd0, req_ready}, {60'd0, 4'(1 << w)});
        e.dat  = golden(dat[w], int'(sh[w]));
        e.id   = 2'(w);
        e.gcyc = cyc;
        q.push_back(e);
        mptr = (w + 1) % N;
        accepted[w] = 1;
      end
      if (rsp_valid) begin
        if (q.size() == 0 || (q.size() == 1 && q[0].gcyc == cyc)) begin
          chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          chk("rsp_data", rsp_data, q[0].dat);
          chk("rsp_id", {62'd0, rsp_id}, {62'd0, q[0].id});
          if (!head_seen) begin
            chk("latency", 64'(cyc - q[0].gcyc), 64'd2);
            head_seen = 1;
          end
          if (rsp_ready) begin
            void'(q.pop_front());
            head_seen = 0;
          end
        end
      end
    end
  end

  // Advance one cycle; requesters whose handshake completed drop their valid.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (accepted[k]) begin
        vld[k] = 0;
        accepted[k] = 0;
      end
    end
  endtask

  task automatic load(input int k, input logic [DW-1:0] d, input int s);
    vld[k] = 1;
    dat[k] = d;
    sh[k]  = SW'(s);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || rsp_valid || vld[0] || vld[1] || vld[2] || vld[3]) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk(name, 64'd1, 64'd0);
  endtask

  initial begin
    logic [DW-1:0] r;
    int            n;
    rst_n = 0;
    rsp_ready = 1;
    for (int k = 0; k < N; k++) begin
      vld[k] = 0; dat[k] = '0; sh[k] = '0; accepted[k] = 0;
    end
    #12;
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_id", {62'd0, rsp_id}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1;
    mon_en = 1;
    step();

    // Single request: -100 >> 3 toward zero is -12, owned by requester 1.
    load(1, -64'sd100, 3);
    wait_idle("single_timeout", 20);

    // Fairness: all requesters kept valid, data k*64 shift 2.
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < N; k++) if (!vld[k]) load(k, 64'(k * 64), 2);
      step();
    end

    // Backpressure: hold the consumer off for 10 cycles after a result appears.
    rsp_ready = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      for (int k = 0; k < N; k++) if (!vld[k]) load(k, 64'(k * 64 + 7), 1);
      step();
      n++;
    end
    if (n >= 20) chk("bp_timeout", 64'd1, 64'd0);
    repeat (10) step();
    rsp_ready = 1;
    @(negedge clk);
    chk("drain_grant", {63'd0, req_ready != 0}, 64'd1);
    step();
    for (int k = 0; k < N; k++) vld[k] = 0;
    wait_idle("bp_drain_timeout", 20);

    // Pointer wrap: only 3, then only 0, then 1 and 2 together (1 wins).
    load(3, 64'd300, 2);
    wait_idle("wrap3_timeout", 20);
    load(0, 64'd40, 2);
    wait_idle("wrap0_timeout", 20);
    load(1, 64'd11, 1);
    load(2, 64'd22, 1);
    wait_idle("wrap12_timeout", 30);

    // Boundary values.
    load(2, 64'h7FFF_FFFF_FFFF_FFFF, 63);
    wait_idle("bnd0_timeout", 20);
    load(2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    wait_idle("bnd1_timeout", 20);
    load(2, 64'd5, 0);
    wait_idle("bnd2_timeout", 20);

    // Reset in the cycle after issue.
    load(2, 64'd1000, 4);
    n = 0;
    while (vld[2] && n < 10) begin
      step();
      n++;
    end
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_data", rsp_data, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_ready", {60'd0, req_ready}, 64'd0);
    q.delete();
    mptr = 0;
    head_seen = 0;
    for (int k = 0; k < N; k++) begin vld[k] = 0; accepted[k] = 0; end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
    repeat (4) step();
    load(3, -64'sd999, 2);
    wait_idle("post_rst_timeout", 20);

    // Randomized traffic with random consumer backpressure.
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!vld[k] && $urandom_range(0, 2) == 0) begin
          r = {$urandom, $urandom};
          if (r == 64'h8000_0000_0000_0000) r = 64'd0;
          load(k, r, $urandom_range(0, 63));
        end
      end
      step();
    end
    rsp_ready = 1;
    wait_idle("final_drain_timeout", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ame_norm_arbiter.md
Name: ame_norm_arbiter

Overview:
- Shares one ame_num_normal engine among NUM_REQ independent requesters.
- Each request carries a signed value and a shift amount. The engine returns sign(x)*(|x|>>s), i.e. a shift with truncation toward zero.
- The block does round-robin arbitration, sequences the engine's init/done pulse, and holds the result in a one-entry response register with valid/ready backpressure.
- It sits between the motion-estimation cost units and the shared normalizer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 64, operand/result width; passed to ame_num_normal as COMP_DATA_BITS.
- ID_BITS, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data_i  in  NUM_REQ*DATA_BITS  packed operands; requester k occupies bits [k*DATA_BITS +: DATA_BITS].
- req_shift_i  in  NUM_REQ*$clog2(DATA_BITS)  packed shift amounts.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer accept.
- rsp_data_o  out  DATA_BITS  normalized result.
- rsp_id_o  out  ID_BITS  index of the requester that owns rsp_data_o.
- busy_o  out  1  high while an operation is in flight or the response register is occupied.

Behaviour:
- Reset (async, rst_n_i=0):
  - req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, busy_o=0.
  - RR pointer=0, in-flight flag=0.
  - Any in-flight operation is discarded; the engine is reset by the same rst_n_i.
- Issue condition in cycle t:
  - in_flight==0, and
  - (rsp_valid_o==0 or rsp_ready_i==1), and
  - at least one req_valid_i bit is set.
- Arbitration:
  - Round-robin, starting the search at index ptr and wrapping modulo NUM_REQ.
  - The winner g gets req_ready_o[g]=1, combinationally, in the same cycle. The handshake completes that cycle.
  - After a grant, ptr is set to (g+1) mod NUM_REQ. Without a grant, ptr holds.
- Engine drive:
  - Engine comp_data_i/comp_shift_i come from requester g's slice, muxed only in the issue cycle.
  - comp_init_i=1 for exactly that one cycle.
  - In other cycles comp_data_i=0 and comp_shift_i=0.
  - On issue, in_flight<=1 and id_q<=g.
- Completion:
  - The engine asserts comp_done_o in cycle t+1.
  - In that cycle: rsp_data_o<=comp_data_o, rsp_id_o<=id_q, rsp_valid_o<=1, in_flight<=0.
  - Engine output is captured only when comp_done_o=1. Its pass-through value in other cycles is ignored.
- Latency:
  - Request handshake in cycle t -> rsp_valid_o high from cycle t+2.
  - Peak throughput is one operation per 2 cycles, with rsp_ready_i held high.
- Response:
  - rsp_valid_o stays high, with rsp_data_o/rsp_id_o stable, until rsp_valid_o&&rsp_ready_i.
  - It then drops, unless a completion loads a new result in the same cycle, in which case it stays high with the new data.
- Backpressure: while rsp_valid_o=1 and rsp_ready_i=0, no issue occurs and all req_ready_o=0. Requesters must hold valid/data stable until ready.
- Simultaneous events:
  - Drain and issue in the same cycle is legal. The new result lands after the register has emptied, so no overflow is possible.
  - A new grant is never given while in_flight=1.
- busy_o = in_flight | rsp_valid_o (registered terms only).
- Arithmetic is defined by ame_num_normal. Golden model: sign(x)*(|x|>>s) for x != -2^(DATA_BITS-1).
  - The most-negative input is passed unchanged to the engine; whatever the engine returns is forwarded, with no special handling here.
- Shift of 0 returns x unchanged. Shift of DATA_BITS-1 returns 0 for all x with |x| < 2^(DATA_BITS-1).

Test Plan:
- Single request: req 1, data=-100, shift=3 -> ready[1] high in cycle t; rsp_valid at t+2 with data=-12, id=1.
- Fairness: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 in order, one every 2 cycles; results for data=k*64, shift=2 give 16k.
- Backpressure: rsp_ready=0 for 10 cycles after the first result -> rsp_data/rsp_id stable, no req_ready asserted. On ready, the next grant comes in the same cycle as the drain.
- Pointer wrap: only req 3 valid, then only req 0 valid -> req 3 granted, then req 0 granted; ptr wraps 3->0->1.
- Boundary values: data=0x7FFF_FFFF_FFFF_FFFF with shift=63 -> 0; data=-1 with shift=1 -> 0; data=5 with shift=0 -> 5.
- Reset mid-operation: assert rst_n_i in the cycle after issue -> all outputs 0 immediately, no rsp_valid after release; the next request completes normally with a correct id.
